// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port seen by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and data ports, one
// transaction at a time; data has priority, a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [3:0] LAT  = 4'(MEM_LATENCY);
    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic              dm;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nx;
    req_t              cur, cur_nx;
    logic [3:0]        lat_cnt, lat_nx;
    logic [3:0]        starve_cnt, starve_nx;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_nx;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_nx;
    logic              pick_dm;

    // Fetch only overtakes a competing data request once it has been passed over STARVE_LIMIT times.
    assign pick_dm = bus.dm_req && !(bus.if_req && starve_cnt == SLIM);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur        <= '0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state      <= state_nx;
            cur        <= cur_nx;
            lat_cnt    <= lat_nx;
            starve_cnt <= starve_nx;
            if_rdata_q <= if_rdata_nx;
            dm_rdata_q <= dm_rdata_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cur_nx      = cur;
        lat_nx      = lat_cnt;
        starve_nx   = starve_cnt;
        if_rdata_nx = if_rdata_q;
        dm_rdata_nx = dm_rdata_q;
        case (state)
            IDLE, RESP: begin
                if (bus.if_req || bus.dm_req) begin
                    state_nx     = ISSUE;
                    cur_nx.dm    = pick_dm;
                    cur_nx.we    = pick_dm && bus.dm_we;
                    cur_nx.addr  = pick_dm ? bus.dm_addr : bus.if_addr;
                    cur_nx.wdata = pick_dm ? bus.dm_wdata : '0;
                    if (bus.if_req && pick_dm)
                        starve_nx = (starve_cnt == SLIM) ? SLIM : starve_cnt + 4'd1;
                    else
                        starve_nx = '0;
                end else begin
                    state_nx  = IDLE;
                    starve_nx = '0;
                end
            end
            ISSUE: begin
                if (cur.we) begin
                    state_nx    = RESP;
                    dm_rdata_nx = '0;
                end else begin
                    state_nx = WAIT;
                    lat_nx   = LAT;
                end
            end
            WAIT: begin
                // Count of 1 marks the cycle in which mem_rdata is valid.
                if (lat_cnt == 4'd1) begin
                    state_nx = RESP;
                    if (cur.dm) dm_rdata_nx = bus.mem_rdata;
                    else        if_rdata_nx = bus.mem_rdata;
                end else begin
                    lat_nx = lat_cnt - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.mem_en    = (state == ISSUE);
    assign bus.mem_we    = bus.mem_en && cur.we;
    assign bus.mem_addr  = bus.mem_en ? cur.addr  : '0;
    assign bus.mem_wdata = bus.mem_en ? cur.wdata : '0;
    assign bus.if_gnt    = bus.mem_en && !cur.dm;
    assign bus.dm_gnt    = bus.mem_en &&  cur.dm;
    assign bus.if_rvalid = (state == RESP) && !cur.dm;
    assign bus.dm_rvalid = (state == RESP) &&  cur.dm;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-schedule model.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, LAT = 2, SLIM = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM))
        dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .STARVE_LIMIT(SLIM))
        u1 (.clock(clock), .reset_n(reset_n), .bus(b1));

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(logic [31:0] a);
        return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
    endfunction

    // memory environment
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] mdl_mem [logic [31:0]];
    int          rd_due = -1;
    logic [31:0] rd_val = '0;

    always @(negedge clock) begin
        if (reset_n && bus.mem_en) begin
            if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
            else begin
                rd_due = cyc + LAT;
                rd_val = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : init_val(bus.mem_addr);
            end
        end
    end

    // schedule model: cycle numbers of issue/response and the next arbitration point
    int          m_iss = -1, m_resp = -1, m_next = 0, m_starve = 0;
    bit          m_dm = 0, m_we = 0, m_ifg_seen = 0, m_dmg_seen = 0;
    logic [31:0] m_addr = '0, m_wd = '0, m_data = '0, m_if_hold = '0, m_dm_hold = '0;

    typedef struct {int c; bit dm; logic we; logic [31:0] addr; logic [31:0] wd;} gev_t;
    typedef struct {int c; bit dm; logic [31:0] d;} rev_t;
    gev_t gq[$];
    rev_t rq[$];
    rev_t r1q[$];

    always @(negedge clock) begin
        bit e_en, e_rv, wdm, ir, dr;
        if (bus.if_gnt || bus.dm_gnt)
            gq.push_back('{c:cyc, dm:bus.dm_gnt, we:bus.mem_we, addr:bus.mem_addr, wd:bus.mem_wdata});
        if (bus.if_rvalid || bus.dm_rvalid)
            rq.push_back('{c:cyc, dm:bus.dm_rvalid, d:(bus.dm_rvalid ? bus.dm_rdata : bus.if_rdata)});
        if (b1.if_rvalid) r1q.push_back('{c:cyc, dm:1'b0, d:b1.if_rdata});
        if (!reset_n) begin
            m_iss = -1; m_resp = -1; m_starve = 0; m_next = cyc + 1;
            m_if_hold = '0; m_dm_hold = '0; m_ifg_seen = 0; m_dmg_seen = 0;
            chk("rst_mem_en", 32'(bus.mem_en), 0);
            chk("rst_gnt", {30'b0, bus.if_gnt, bus.dm_gnt}, 0);
            chk("rst_rvalid", {30'b0, bus.if_rvalid, bus.dm_rvalid}, 0);
        end else begin
            e_en = (cyc == m_iss);
            e_rv = (cyc == m_resp);
            if (e_rv) begin
                if (m_dm) m_dm_hold = m_we ? 32'h0 : m_data;
                else      m_if_hold = m_data;
            end
            chk("mem_en",    32'(bus.mem_en),    32'(e_en));
            chk("mem_we",    32'(bus.mem_we),    32'(e_en && m_we));
            chk("mem_addr",  bus.mem_addr,       e_en ? m_addr : 32'h0);
            chk("mem_wdata", bus.mem_wdata,      e_en ? m_wd : 32'h0);
            chk("if_gnt",    32'(bus.if_gnt),    32'(e_en && !m_dm));
            chk("dm_gnt",    32'(bus.dm_gnt),    32'(e_en && m_dm));
            chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_rv && !m_dm));
            chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(e_rv && m_dm));
            chk("if_rdata",  bus.if_rdata,       m_if_hold);
            chk("dm_rdata",  bus.dm_rdata,       m_dm_hold);
            m_ifg_seen = e_en && !m_dm;
            m_dmg_seen = e_en && m_dm;
            if (cyc == m_next) begin
                ir = bus.if_req; dr = bus.dm_req;
                if (ir || dr) begin
                    wdm      = dr && !(ir && m_starve == SLIM);
                    m_starve = (ir && wdm) ? ((m_starve + 1 > SLIM) ? SLIM : m_starve + 1) : 0;
                    m_dm     = wdm;
                    m_we     = wdm && bus.dm_we;
                    m_addr   = wdm ? bus.dm_addr : bus.if_addr;
                    m_wd     = wdm ? bus.dm_wdata : 32'h0;
                    if (m_we) mdl_mem[m_addr] = m_wd;
                    else m_data = mdl_mem.exists(m_addr) ? mdl_mem[m_addr] : init_val(m_addr);
                    m_iss  = cyc + 1;
                    m_resp = cyc + 2 + (m_we ? 0 : LAT);
                    m_next = m_resp;
                end else begin
                    m_starve = 0;
                    m_next   = cyc + 1;
                end
            end
        end
    end

    // requesters: 0 random, 1 manual (drop after grant), 2 always re-request
    int if_mode = 1, dm_mode = 1;

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    task automatic drive();
        if (m_ifg_seen) begin
            if (if_mode == 2 || (if_mode == 0 && $urandom_range(0, 1) == 1)) begin
                bus.if_req = 1'b1; bus.if_addr = rnd_addr();
            end else bus.if_req = 1'b0;
        end else if (if_mode == 0 && !bus.if_req && $urandom_range(0, 2) == 0) begin
            bus.if_req = 1'b1; bus.if_addr = rnd_addr();
        end
        if (m_dmg_seen) begin
            if (dm_mode == 2 || (dm_mode == 0 && $urandom_range(0, 1) == 1)) begin
                bus.dm_req = 1'b1; bus.dm_addr = rnd_addr();
                bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_wdata = $urandom;
            end else bus.dm_req = 1'b0;
        end else if (dm_mode == 0 && !bus.dm_req && $urandom_range(0, 2) == 0) begin
            bus.dm_req = 1'b1; bus.dm_addr = rnd_addr();
            bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_wdata = $urandom;
        end
        bus.mem_rdata = (cyc == rd_due) ? rd_val : $urandom;
        b1.mem_rdata  = 32'(cyc) ^ 32'h5A00_0000;
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clock); #1;
            drive();
        end
    endtask

    initial begin
        int s;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;
        b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0;
        b1.dm_addr = '0; b1.dm_wdata = '0; b1.mem_rdata = '0;
        #12;
        chk("reset_outputs", {26'b0, bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid,
                              bus.mem_en, bus.mem_we}, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_mem_wdata", bus.mem_wdata, 0);
        chk("reset_rdata", bus.if_rdata | bus.dm_rdata, 0);
        step(1);
        reset_n = 1'b1;
        step(3);

        // latency-1 build: back-to-back fetch reads
        s = cyc; b1.if_req = 1'b1; b1.if_addr = 32'h4;
        step(12);
        b1.if_req = 1'b0;
        step(4);
        chk("l1_rvalid_count_ge3", 32'(r1q.size() >= 3), 1);
        if (r1q.size() >= 3) begin
            chk("l1_first_latency", 32'(r1q[0].c - s), 3);
            chk("l1_spacing_a", 32'(r1q[1].c - r1q[0].c), 3);
            chk("l1_spacing_b", 32'(r1q[2].c - r1q[1].c), 3);
            for (int i = 0; i < 3; i++)
                chk("l1_rdata", r1q[i].d, 32'(r1q[i].c - 1) ^ 32'h5A00_0000);
        end

        // single fetch read
        env_mem[32'h8] = 32'h0000_0013; mdl_mem[32'h8] = 32'h0000_0013;
        gq.delete(); rq.delete();
        s = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h8;
        step(8);
        chk("fetch_gnt_count", 32'(gq.size()), 1);
        chk("fetch_rvalid_count", 32'(rq.size()), 1);
        if (gq.size() > 0) begin
            chk("fetch_gnt_cycle", 32'(gq[0].c - s), 1);
            chk("fetch_mem_addr", gq[0].addr, 32'h8);
            chk("fetch_mem_we", 32'(gq[0].we), 0);
        end
        if (rq.size() > 0) begin
            chk("fetch_rvalid_cycle", 32'(rq[0].c - s), 4);
            chk("fetch_rdata", rq[0].d, 32'h0000_0013);
        end

        // store then load
        gq.delete(); rq.delete();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
        step(4);
        if (gq.size() > 0) begin
            chk("sw_mem_we", 32'(gq[0].we), 1);
            chk("sw_mem_wdata", gq[0].wd, 32'hDEAD_BEEF);
        end
        chk("sw_rvalid_count", 32'(rq.size()), 1);
        if (rq.size() > 0 && gq.size() > 0) begin
            chk("sw_rvalid_cycle", 32'(rq[0].c - gq[0].c), 1);
            chk("sw_rdata_zero", rq[0].d, 0);
        end
        gq.delete(); rq.delete();
        s = cyc; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40; bus.dm_wdata = 32'h1234;
        step(6);
        if (rq.size() > 0) begin
            chk("lw_rdata", rq[0].d, 32'hDEAD_BEEF);
            chk("lw_latency", 32'(rq[0].c - s), 4);
        end else chk("lw_rvalid_count", 32'(rq.size()), 1);

        // simultaneous requests
        gq.delete(); rq.delete();
        s = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10;
        step(12);
        chk("sim_gnt_count", 32'(gq.size()), 2);
        if (gq.size() >= 2) begin
            chk("sim_first_dm", 32'(gq[0].dm), 1);
            chk("sim_first_cycle", 32'(gq[0].c - s), 1);
            chk("sim_second_if", 32'(gq[1].dm), 0);
            chk("sim_second_cycle", 32'(gq[1].c - s), 5);
        end

        // starvation: both held high continuously
        gq.delete(); rq.delete();
        if_mode = 2; dm_mode = 2;
        bus.if_req = 1'b1; bus.if_addr = 32'h24;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h28;
        step(60);
        if_mode = 1; dm_mode = 1;
        step(20);
        chk("starve_gnt_count_ge10", 32'(gq.size() >= 10), 1);
        if (gq.size() >= 10)
            for (int i = 0; i < 10; i++)
                chk("starve_pattern", 32'(gq[i].dm), 32'((i % 5) != 4));

        // reset during WAIT
        gq.delete(); rq.delete();
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        step(2);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(bus.mem_en), 0);
        chk("midrst_ctl", {28'b0, bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid}, 0);
        chk("midrst_if_rdata", bus.if_rdata, 0);
        chk("midrst_dm_rdata", bus.dm_rdata, 0);
        chk("midrst_mem_addr", bus.mem_addr, 0);
        bus.if_req = 1'b0;
        rq.delete();
        step(2);
        reset_n = 1'b1;
        step(6);
        chk("midrst_no_rvalid", 32'(rq.size()), 0);
        rq.delete();
        s = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h8;
        step(8);
        chk("postrst_rvalid_count", 32'(rq.size()), 1);
        if (rq.size() > 0) begin
            chk("postrst_latency", 32'(rq[0].c - s), 4);
            chk("postrst_rdata", rq[0].d, 32'h0000_0013);
        end

        // randomized traffic
        if_mode = 0; dm_mode = 0;
        step(3000);
        if_mode = 1; dm_mode = 1;
        step(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
